// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the multi-port integer register file:
//   - rf_state_e : sweep FSM encoding (RF_INIT while clearing, RF_RUN once usable)
//   - RF_DEF_AW / RF_DEF_DW : default index and data widths
//   - RF_X0 : index of the hardwired-zero register
// ---------------------------------------------------------------------------
package rf_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam int RF_DEF_AW = 5;
  localparam int RF_DEF_DW = 32;
  localparam int RF_X0     = 0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// Per-register busy bits used for RAW hazard detection. A bit is set when an
// instruction with that destination issues and cleared when writeback
// writes the register. Register x0 is never busy.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset (all bits cleared)
//   set_en       : mark set_addr busy on the next posedge
//   set_addr     : register receiving a new producer
//   clr_en       : clear busy bit of clr_addr on the next posedge
//   clr_addr     : register being written back
//   raddr        : NR lookup indices, port p at [p*AW +: AW]
//   busy_rd      : busy bit of each lookup index (registered value, no bypass)
//
// Callers gate set_en/clr_en themselves (x0, init lockout); this block only
// resolves priority: on a same-edge set and clear of one index the set wins,
// since the newly issued producer supersedes the one retiring.
// ---------------------------------------------------------------------------
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int AW = RF_DEF_AW,
  parameter int NR = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_addr,
  input  logic [NR*AW-1:0] raddr,
  output logic [NR-1:0]    busy_rd
);

  localparam int DEPTH = 1 << AW;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  // Clear applied first so that a same-index set overrides it.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_addr] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    busy_nxt[RF_X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_comb begin
    busy_rd = '0;
    for (int p = 0; p < NR; p++) begin
      busy_rd[p] = busy[raddr[p*AW +: AW]];
    end
  end

endmodule : rf_scoreboard

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-read-port integer register file: one write port, NR combinational
// read ports, x0 hardwired to zero, a post-reset clearing sweep and a busy
// scoreboard for hazard detection.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   ready      : 1 once the clearing sweep is done; 0 during INIT. This is
//                also the sweep FSM state (0 = RF_INIT, 1 = RF_RUN).
//   wen/waddr/wdata : write port, applied on posedge while ready
//   raddr/rdata     : NR read ports, zero latency
//   rbusy           : per-port "source has an outstanding producer"
//   set_en/set_addr : mark a destination busy at issue
//
// Interface semantics: there is no handshake; ready is a level status. While
// ready=0 writes and busy sets are dropped (not held), all rdata read 0 and
// all rbusy read 0. While ready=1 every wen/set_en pulse takes effect on the
// posedge it is sampled.
//
// The array itself has no reset: after reset the sweep writes 0 to indices
// 1..DEPTH-1 (one per cycle), and reads are masked to 0 until it finishes,
// so stale or X contents never reach the outputs.
// ---------------------------------------------------------------------------
module regfile_mp
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_DEF_AW,
  parameter int DATA_WIDTH = RF_DEF_DW,
  parameter int NR         = 2,
  parameter int BYPASS     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  input  logic                     wen,
  input  logic [ADDR_WIDTH-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [NR*ADDR_WIDTH-1:0] raddr,
  output logic [NR*DATA_WIDTH-1:0] rdata,
  output logic [NR-1:0]            rbusy,
  input  logic                     set_en,
  input  logic [ADDR_WIDTH-1:0]    set_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0_IDX   = ADDR_WIDTH'(RF_X0);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  rf_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_cnt, sweep_cnt_nxt;
  logic                  sweep_we;
  logic                  wr_fire;
  logic                  set_fire;
  logic [NR-1:0]         busy_rd;
  logic [ADDR_WIDTH-1:0] ra;

  logic [DATA_WIDTH-1:0] rf [DEPTH];

  // -------------------------------------------------------------------------
  // Sweep FSM. Starts at index 1 (x0 is never read from the array), so the
  // sweep lasts DEPTH-1 cycles and hands over to RUN after the last index.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RF_INIT;
      sweep_cnt <= ADDR_WIDTH'(1);
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    sweep_we      = 1'b0;
    case (state)
      RF_INIT: begin
        sweep_we      = 1'b1;
        sweep_cnt_nxt = sweep_cnt + ADDR_WIDTH'(1);
        if (sweep_cnt == LAST_IDX) state_nxt = RF_RUN;
      end
      RF_RUN: begin
        state_nxt = RF_RUN;
      end
      default: begin
        state_nxt = RF_INIT;
      end
    endcase
  end

  assign ready    = (state == RF_RUN);
  assign wr_fire  = ready && wen && (waddr != X0_IDX);
  assign set_fire = ready && set_en && (set_addr != X0_IDX);

  // -------------------------------------------------------------------------
  // Data array (no reset; cleared by the sweep).
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (sweep_we)     rf[sweep_cnt] <= '0;
    else if (wr_fire) rf[waddr]     <= wdata;
  end

  // -------------------------------------------------------------------------
  // Busy scoreboard: writeback clears, issue sets.
  // -------------------------------------------------------------------------
  rf_scoreboard #(
    .AW (ADDR_WIDTH),
    .NR (NR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_fire),
    .set_addr (set_addr),
    .clr_en   (wr_fire),
    .clr_addr (waddr),
    .raddr    (raddr),
    .busy_rd  (busy_rd)
  );

  // -------------------------------------------------------------------------
  // Read ports. With bypass, a same-cycle write to the read index supplies
  // the data and also reports the source as no longer busy, since the
  // producer's value is already on the bus.
  // -------------------------------------------------------------------------
  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    for (int p = 0; p < NR; p++) begin
      ra = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (ready && (ra != X0_IDX)) begin
        rdata[p*DATA_WIDTH +: DATA_WIDTH] = rf[ra];
        rbusy[p]                          = busy_rd[p];
        if ((BYPASS != 0) && wr_fire && (waddr == ra)) begin
          rdata[p*DATA_WIDTH +: DATA_WIDTH] = wdata;
          rbusy[p]                          = 1'b0;
        end
      end
    end
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Two instances share all inputs: u_dut_b1 (BYPASS=1) and u_dut_b0
// (BYPASS=0). A reference model (array of register values, array of busy
// flags, count of sweep cycles left) predicts every output.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wen = 1'b0;
  logic [AW-1:0]    waddr = '0;
  logic [DW-1:0]    wdata = '0;
  logic [NR*AW-1:0] raddr = '0;
  logic             set_en = 1'b0;
  logic [AW-1:0]    set_addr = '0;

  logic             ready1, ready0;
  logic [NR*DW-1:0] rdata1, rdata0;
  logic [NR-1:0]    rbusy1, rbusy0;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [DW-1:0] m_rf   [DEPTH];
  bit            m_busy [DEPTH];
  int            m_init;

  always #5 clk = ~clk;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .BYPASS(1)) u_dut_b1 (
    .clk(clk), .rst_n(rst_n), .ready(ready1), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata1), .rbusy(rbusy1),
    .set_en(set_en), .set_addr(set_addr)
  );

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR(NR), .BYPASS(0)) u_dut_b0 (
    .clk(clk), .rst_n(rst_n), .ready(ready0), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata0), .rbusy(rbusy0),
    .set_en(set_en), .set_addr(set_addr)
  );

  // ---------------- model ----------------
  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
    m_init = DEPTH - 1;
  endtask

  function automatic logic [AW-1:0] port_addr(int p);
    return raddr[p*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] exp_rdata(int p, bit byp);
    logic [AW-1:0] a;
    a = port_addr(p);
    if (m_init != 0 || a == 0) return '0;
    if (byp && wen && waddr == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic logic exp_rbusy(int p, bit byp);
    logic [AW-1:0] a;
    a = port_addr(p);
    if (m_init != 0 || a == 0) return 1'b0;
    if (byp && wen && waddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  // One clock edge; model consumes the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (m_init > 0) begin
        m_init--;
      end else begin
        if (wen && waddr != 0) begin
          m_rf[waddr]   = wdata;
          m_busy[waddr] = 1'b0;
        end
        if (set_en && set_addr != 0) m_busy[set_addr] = 1'b1;
      end
    end
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic s, input logic [AW-1:0] sa,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    wen      = w;
    waddr    = wa;
    wdata    = wd;
    set_en   = s;
    set_addr = sa;
    raddr    = {r1, r0};
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, AW'($urandom_range(1, 31)), $urandom, 1'b1, AW'($urandom_range(1, 31)),
            AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      n_checks++;
      if (ready1 !== 1'b0 || rdata1 !== '0 || rbusy1 !== '0) begin
        n_fail++;
        $display("FAIL reset_hold: ready=%b rdata=%h rbusy=%b required 0/0/0", ready1, rdata1, rbusy1);
      end
      tick();
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      drive(1'b0, '0, '0, 1'b0, '0, AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
      n_checks++;
      if (ready1 !== (c == 32) || ready0 !== (c == 32)) begin
        n_fail++;
        $display("FAIL reset_ready cycle %0d: ready1=%b ready0=%b required %b", c, ready1, ready0, c == 32);
      end
      n_checks++;
      if (rdata1 !== '0 || rdata0 !== '0) begin
        n_fail++;
        $display("FAIL reset_rdata cycle %0d: rdata1=%h rdata0=%h required 0", c, rdata1, rdata0);
      end
      if (c < 32) tick();
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, '0, '0, 1'b0, '0, AW'(a), AW'(a));
      n_checks++;
      if (rdata1 !== '0 || rbusy1 !== '0) begin
        n_fail++;
        $display("FAIL reset_swept idx %0d: rdata=%h rbusy=%b required 0/0", a, rdata1, rbusy1);
      end
    end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, '0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
    n_checks++;
    if (rdata1[31:0] !== 32'hDEADBEEF || rdata0[63:32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_read r5: got %h / %h required deadbeef", rdata1[31:0], rdata0[63:32]);
    end
    drive(1'b1, 5'd0, 32'h1, 1'b0, '0, 5'd0, 5'd0);
    n_checks++;
    if (rdata1 !== '0 || rdata0 !== '0) begin
      n_fail++;
      $display("FAIL write_x0_same: rdata1=%h rdata0=%h required 0", rdata1, rdata0);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd5);
    n_checks++;
    if (rdata1[31:0] !== '0 || rdata1[63:32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_x0_after: x0=%h r5=%h required 0 / deadbeef", rdata1[31:0], rdata1[63:32]);
    end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'h11, 1'b0, '0, '0, '0);
    tick();
    drive(1'b1, 5'd7, 32'h22, 1'b0, '0, 5'd0, 5'd7);
    n_checks++;
    if (rdata1[63:32] !== 32'h22) begin
      n_fail++;
      $display("FAIL bypass_on: got %h required 00000022", rdata1[63:32]);
    end
    n_checks++;
    if (rdata0[63:32] !== 32'h11) begin
      n_fail++;
      $display("FAIL bypass_off: got %h required 00000011", rdata0[63:32]);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd7);
    n_checks++;
    if (rdata1[63:32] !== 32'h22 || rdata0[63:32] !== 32'h22) begin
      n_fail++;
      $display("FAIL bypass_after: got %h / %h required 00000022", rdata1[63:32], rdata0[63:32]);
    end
  endtask

  task automatic test_scoreboard();
    drive(1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd9);
    n_checks++;
    if (rbusy1 !== 2'b00) begin
      n_fail++;
      $display("FAIL sb_before_set: rbusy=%b required 00", rbusy1);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    n_checks++;
    if (rbusy1 !== 2'b11 || rbusy0 !== 2'b11) begin
      n_fail++;
      $display("FAIL sb_set: rbusy1=%b rbusy0=%b required 11", rbusy1, rbusy0);
    end
    drive(1'b1, 5'd9, 32'h99, 1'b0, '0, 5'd9, 5'd0);
    n_checks++;
    if (rbusy1[0] !== 1'b0 || rbusy0[0] !== 1'b1 || rdata1[31:0] !== 32'h99) begin
      n_fail++;
      $display("FAIL sb_clear_same: rbusy1=%b rbusy0=%b rdata1=%h required 0/1/99",
               rbusy1[0], rbusy0[0], rdata1[31:0]);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
    n_checks++;
    if (rbusy1 !== 2'b00 || rbusy0 !== 2'b00) begin
      n_fail++;
      $display("FAIL sb_cleared: rbusy1=%b rbusy0=%b required 00", rbusy1, rbusy0);
    end
    drive(1'b1, 5'd9, 32'h77, 1'b1, 5'd9, 5'd9, 5'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd0);
    n_checks++;
    if (rbusy1[0] !== 1'b1 || rbusy0[0] !== 1'b1 || rdata1[31:0] !== 32'h77) begin
      n_fail++;
      $display("FAIL sb_set_wins: rbusy1=%b rbusy0=%b rdata=%h required 1/1/77",
               rbusy1[0], rbusy0[0], rdata1[31:0]);
    end
    drive(1'b1, 5'd9, 32'h5, 1'b1, 5'd10, 5'd0, 5'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd10);
    n_checks++;
    if (rbusy1 !== 2'b10 || rbusy0 !== 2'b10) begin
      n_fail++;
      $display("FAIL sb_diff_idx: rbusy1=%b rbusy0=%b required 10", rbusy1, rbusy0);
    end
    drive(1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0);
    n_checks++;
    if (rbusy1 !== 2'b00) begin
      n_fail++;
      $display("FAIL sb_x0: rbusy=%b required 00", rbusy1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
            AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)));
      for (int p = 0; p < NR; p++) begin
        n_checks++;
        if (rdata1[p*DW +: DW] !== exp_rdata(p, 1'b1) || rdata0[p*DW +: DW] !== exp_rdata(p, 1'b0)) begin
          n_fail++;
          $display("FAIL rand_rdata it %0d port %0d: b1=%h b0=%h required %h / %h", i, p,
                   rdata1[p*DW +: DW], rdata0[p*DW +: DW], exp_rdata(p, 1'b1), exp_rdata(p, 1'b0));
        end
        n_checks++;
        if (rbusy1[p] !== exp_rbusy(p, 1'b1) || rbusy0[p] !== exp_rbusy(p, 1'b0)) begin
          n_fail++;
          $display("FAIL rand_rbusy it %0d port %0d: b1=%b b0=%b required %b / %b", i, p,
                   rbusy1[p], rbusy0[p], exp_rbusy(p, 1'b1), exp_rbusy(p, 1'b0));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 5'd0, 5'd0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd3);
    n_checks++;
    if (rdata1[31:0] !== 32'hAA || rbusy1 !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_pre: rdata=%h rbusy=%b required aa / 11", rdata1[31:0], rbusy1);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (ready1 !== 1'b0 || ready0 !== 1'b0 || rdata1 !== '0 || rbusy1 !== '0) begin
      n_fail++;
      $display("FAIL midrst_drop: ready=%b rdata=%h rbusy=%b required 0/0/0", ready1, rdata1, rbusy1);
    end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH - 1; c++) begin
      n_checks++;
      if (ready1 !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_sweep cycle %0d: ready=%b required 0", c, ready1);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd3);
    n_checks++;
    if (ready1 !== 1'b1 || rdata1 !== '0 || rbusy1 !== '0 || rbusy0 !== '0) begin
      n_fail++;
      $display("FAIL midrst_after: ready=%b rdata=%h rbusy=%b required 1/0/00", ready1, rdata1, rbusy1);
    end
  endtask

  task automatic test_init_lockout();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    drive(1'b1, 5'd4, 32'h55, 1'b1, 5'd4, 5'd4, 5'd4);
    for (int c = 0; c < DEPTH - 1; c++) begin
      n_checks++;
      if (rdata1 !== '0 || rbusy1 !== '0 || rdata0 !== '0) begin
        n_fail++;
        $display("FAIL lockout_init cycle %0d: rdata=%h rbusy=%b required 0/0", c, rdata1, rbusy1);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd4);
    n_checks++;
    if (ready1 !== 1'b1 || rdata1 !== '0 || rbusy1 !== '0) begin
      n_fail++;
      $display("FAIL lockout_after: ready=%b rdata=%h rbusy=%b required 1/0/00", ready1, rdata1, rbusy1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_random();
    test_reset_mid_op();
    test_init_lockout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_mp
